// File: rtl/sample_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sample_bank_buffer
// Purpose  : Banked single-port sample store with record/playback sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module sample_bank_buffer #(
  parameter int DATA_W  = 16,
  parameter int BANK_AW = 14,
  parameter int BANKS   = 4,
  localparam int SEL_W  = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int AW     = BANK_AW + SEL_W,
  localparam int DEPTH  = BANKS * (2 ** BANK_AW)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              loop_rec,
  input  logic              loop_play,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_req,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic              done,
  output logic [AW:0]       length
);

  localparam logic [1:0]    c_idle      = 2'd0;
  localparam logic [1:0]    c_rec       = 2'd1;
  localparam logic [1:0]    c_play      = 2'd2;
  localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
  localparam logic [AW-1:0] c_ptr_one   = AW'(1);
  localparam logic [AW:0]   c_len_one   = (AW+1)'(1);
  localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);

  logic [1:0]        r_state;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_cnt;
  logic [AW:0]       r_length;
  logic              r_full;
  logic              r_wrapped;
  logic              r_done;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_sel;

  logic              w_we;
  logic              w_re;
  logic              w_last_wr;
  logic              w_last_rd;
  logic [AW-1:0]     w_addr;
  logic [AW-1:0]     w_start_ptr;
  logic [AW-1:0]     w_wr_next;
  logic [AW-1:0]     w_rd_next;
  logic [DATA_W-1:0] w_bank_q [BANKS];

  // rec_start outranks every other control, so it also blocks the write/read
  always_comb begin
    w_we        = (r_state == c_rec) && in_valid && !rec_start;
    w_re        = (r_state == c_play) && out_req && !stop && !rec_start;
    w_addr      = (r_state == c_rec) ? r_wr_ptr : r_rd_ptr;
    w_start_ptr = r_wrapped ? r_wr_ptr : '0;
    w_last_wr   = (r_wr_ptr == c_last_addr);
    w_last_rd   = ({1'b0, r_cnt} == (r_length - c_len_one));
    w_wr_next   = w_last_wr ? '0 : r_wr_ptr + c_ptr_one;
    w_rd_next   = (r_rd_ptr == c_last_addr) ? '0 : r_rd_ptr + c_ptr_one;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [2**BANK_AW];
    logic [DATA_W-1:0] r_q;
    logic              w_bank_we;

    assign w_bank_we = w_we && (w_addr[AW-1:BANK_AW] == SEL_W'(b));

    always_ff @(posedge clk) begin
      if (w_bank_we) begin
        r_mem[w_addr[BANK_AW-1:0]] <= in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_q <= '0;
      end else if (w_re) begin
        r_q <= r_mem[w_addr[BANK_AW-1:0]];
      end
    end

    assign w_bank_q[b] = r_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= c_idle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_length    <= '0;
      r_full      <= 1'b0;
      r_wrapped   <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_sel       <= '0;
    end else begin
      r_out_valid <= w_re;
      r_done      <= w_re && w_last_rd && !loop_play;
      // select travels with the read so the mux matches the returning data
      if (w_re) begin
        r_sel <= r_rd_ptr[AW-1:BANK_AW];
      end

      if (rec_start) begin
        r_state   <= c_rec;
        r_wr_ptr  <= '0;
        r_length  <= '0;
        r_full    <= 1'b0;
        r_wrapped <= 1'b0;
      end else begin
        case (r_state)
          c_idle: begin
            if (play_start && (r_length != '0)) begin
              r_state  <= c_play;
              r_rd_ptr <= w_start_ptr;
              r_cnt    <= '0;
            end
          end
          c_rec: begin
            if (w_we) begin
              r_wr_ptr <= w_wr_next;
              if (r_length != c_depth) begin
                r_length <= r_length + c_len_one;
              end
              if (w_last_wr) begin
                if (loop_rec) begin
                  r_wrapped <= 1'b1;
                end else begin
                  r_full  <= 1'b1;
                  r_state <= c_idle;
                end
              end
            end
            if (stop) begin
              r_state <= c_idle;
            end
          end
          c_play: begin
            if (stop) begin
              r_state <= c_idle;
            end else if (w_re) begin
              if (w_last_rd) begin
                if (loop_play) begin
                  r_rd_ptr <= w_start_ptr;
                  r_cnt    <= '0;
                end else begin
                  r_state <= c_idle;
                end
              end else begin
                r_rd_ptr <= w_rd_next;
                r_cnt    <= r_cnt + c_ptr_one;
              end
            end
          end
          default: r_state <= c_idle;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = w_bank_q[r_sel];
  assign recording = (r_state == c_rec);
  assign playing   = (r_state == c_play);
  assign full      = r_full;
  assign done      = r_done;
  assign length    = r_length;

endmodule
`default_nettype wire

// File: tb/tb_sample_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_bank_buffer
// Purpose  : Randomized scoreboard bench for sample_bank_buffer (2 x 16 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_bank_buffer;

  localparam int DATA_W  = 16;
  localparam int BANK_AW = 4;
  localparam int BANKS   = 2;
  localparam int DEPTH   = 32;
  localparam int BUDGET  = 2000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rec_start, play_start, stop, loop_rec, loop_play;
  logic              in_valid, out_req;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, recording, playing, full, done;
  logic [DATA_W-1:0] out_data;
  logic [5:0]        length;

  always #5 clk = ~clk;

  sample_bank_buffer #(.DATA_W(DATA_W), .BANK_AW(BANK_AW), .BANKS(BANKS)) dut (
    .clk(clk), .reset_n(reset_n), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .loop_rec(loop_rec), .loop_play(loop_play), .in_valid(in_valid),
    .in_data(in_data), .out_req(out_req), .out_valid(out_valid), .out_data(out_data),
    .recording(recording), .playing(playing), .full(full), .done(done), .length(length)
  );

  typedef struct { logic [DATA_W-1:0] d; logic dn; } exp_t;
  exp_t              sb[$];
  logic [DATA_W-1:0] take[$];
  bit                mfull;
  int                tests = 0;
  int                errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // monitor: every returned sample must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_out_valid: out_valid=1 data=%0h with nothing outstanding", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("done_with_valid", 32'(done), 32'(e.dn));
      end
    end else begin
      chk("done_without_valid", 32'(done), 32'd0);
    end
  end

  // mode 0: base+i, 1: index, 2: random; take model keeps the newest DEPTH samples
  task automatic record(input int n, input bit lp, input int mode, input logic [DATA_W-1:0] base,
                        input bit stop_end, input bit stop_with_last);
    logic [DATA_W-1:0] v;
    int i = 0;
    int guard = 0;
    rec_start = 1'b1; loop_rec = lp; tick; rec_start = 1'b0;
    take.delete();
    mfull = 1'b0;
    while (i < n && guard < BUDGET) begin
      guard++;
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        v = (mode == 0) ? base + DATA_W'(i) : (mode == 1) ? DATA_W'(i) : DATA_W'($urandom);
        in_data = v;
        take.push_back(v);
        if (take.size() > DEPTH) take.delete(0);
        if (!lp && take.size() == DEPTH) mfull = 1'b1;
        i++;
        if (i == n && stop_with_last) stop = 1'b1;
      end else begin
        in_data = DATA_W'($urandom);
      end
      tick;
    end
    chk("record_budget", 32'(i), 32'(n));
    in_valid = 1'b0;
    stop = 1'b0;
    if (stop_end) begin
      stop = 1'b1; tick; stop = 1'b0;
    end
  endtask

  task automatic play(input int nreq, input bit lp, input bit hold, input bit stop_end);
    int issued = 0;
    int guard = 0;
    int len = take.size();
    exp_t e;
    play_start = 1'b1; loop_play = lp; tick; play_start = 1'b0;
    while (issued < nreq && guard < BUDGET) begin
      guard++;
      out_req = hold || ($urandom_range(0, 2) != 0);
      if (out_req) begin
        e.d  = take[issued % len];
        e.dn = !lp && (issued == len - 1);
        sb.push_back(e);
        issued++;
      end
      tick;
      if (hold) chk("back_to_back_valid", 32'(out_valid), 32'd1);
    end
    chk("play_budget", 32'(issued), 32'(nreq));
    if (stop_end) begin
      stop = 1'b1; out_req = 1'b1; tick; stop = 1'b0;
      chk("no_valid_after_stop", 32'(out_valid), 32'd0);
    end
    out_req = 1'b0;
    tick;
    chk("playing_after", 32'(playing), 32'd0);
    repeat (2) tick;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    loop_rec = 1'b0; loop_play = 1'b0; in_valid = 1'b0; out_req = 1'b0; in_data = '0;
    tick; tick;
    chk("rst_recording", 32'(recording), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_length", 32'(length), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    reset_n = 1'b1;

    // reset in the middle of a recording
    rec_start = 1'b1; tick; rec_start = 1'b0;
    in_valid = 1'b1; in_data = 16'hABCD; tick; tick;
    chk("pre_reset_length", 32'(length), 32'd2);
    reset_n = 1'b0; tick; tick;
    chk("midrec_rst_recording", 32'(recording), 32'd0);
    chk("midrec_rst_length", 32'(length), 32'd0);
    chk("midrec_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrec_rst_full", 32'(full), 32'd0);
    reset_n = 1'b1; in_valid = 1'b0;

    // 20-sample take, continuous playback
    record(20, 1'b0, 0, 16'h1000, 1'b1, 1'b0);
    chk("t20_length", 32'(length), 32'd20);
    chk("t20_recording", 32'(recording), 32'd0);
    play(20, 1'b0, 1'b1, 1'b0);

    // full store spanning both banks
    record(32, 1'b0, 1, '0, 1'b0, 1'b0);
    chk("full_flag", 32'(full), 32'(mfull));
    chk("full_length", 32'(length), 32'd32);
    chk("full_recording", 32'(recording), 32'd0);
    play(32, 1'b0, 1'b0, 1'b0);
    chk("full_sticky", 32'(full), 32'd1);
    reset_n = 1'b0; tick; reset_n = 1'b1;
    chk("full_cleared_by_reset", 32'(full), 32'd0);

    // circular recording keeps the newest DEPTH samples
    record(40, 1'b1, 1, '0, 1'b1, 1'b0);
    chk("circ_length", 32'(length), 32'(take.size()));
    chk("circ_full", 32'(full), 32'd0);
    play(32, 1'b0, 1'b0, 1'b0);

    // looped playback of a 3-sample take, then stop with a read in flight
    record(3, 1'b0, 2, '0, 1'b1, 1'b0);
    chk("loop_length", 32'(length), 32'd3);
    play(7, 1'b1, 1'b1, 1'b1);

    // simultaneous rec_start/play_start picks recording
    rec_start = 1'b1; play_start = 1'b1; tick; rec_start = 1'b0; play_start = 1'b0;
    chk("simul_recording", 32'(recording), 32'd1);
    chk("simul_playing", 32'(playing), 32'd0);
    stop = 1'b1; tick; stop = 1'b0;

    // last sample arrives together with stop
    record(5, 1'b0, 2, '0, 1'b0, 1'b1);
    chk("stopwrite_length", 32'(length), 32'd5);
    chk("stopwrite_recording", 32'(recording), 32'd0);
    play(5, 1'b0, 1'b0, 1'b0);

    // empty take: play_start ignored, out_req in IDLE produces nothing
    rec_start = 1'b1; tick; rec_start = 1'b0;
    stop = 1'b1; tick; stop = 1'b0;
    take.delete();
    chk("empty_length", 32'(length), 32'd0);
    play_start = 1'b1; tick; play_start = 1'b0;
    chk("empty_play_ignored", 32'(playing), 32'd0);
    out_req = 1'b1; tick; out_req = 1'b0; tick; tick;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
